// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: field widths, opcode values, FSM encodings.
package instr_fetch_unit_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 5;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t LOAD_A = 3'b000;
  localparam opcode_t LOAD_B = 3'b001;
  localparam opcode_t STORE  = 3'b010;
  localparam opcode_t JMP    = 3'b100;
  localparam opcode_t ALU    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_VALID = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: load has priority over increment; wraps modulo 2^ADDR_W.
module pc_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              incr_en,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load_en) begin
      pc <= load_value;
    end else if (incr_en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: requests the word at pc from imem, holds it in ir and issues it to the decoder.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              exec_ready,
  input  logic              jmp,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state;
  logic [DATA_W-1:0] ir;
  logic              accept;

  assign accept    = (state == ST_VALID) && exec_ready;
  assign imem_addr = pc;
  assign opcode    = ir[DATA_W-1 -: OP_W];
  assign operand   = ir[ADDR_W-1:0];

  pc_reg u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (accept && jmp),
    .load_value (operand),
    .incr_en    (accept && !jmp),
    .pc         (pc)
  );

  // Fetch FSM; a started request always runs to its ack, so run only matters at IDLE and accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            state       <= ST_VALID;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ST_VALID: begin
          if (exec_ready) begin
            instr_valid <= 1'b0;
            if (run) begin
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small behavioural imem of programmable ack latency.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       instr_valid;
  logic       exec_ready;
  logic       jmp;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [4:0] pc;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [32];
  logic       auto_imem;
  int         ack_delay;
  int         wait_cnt;
  logic       model_ack;
  logic [7:0] model_rdata;
  logic       man_ack;
  logic [7:0] man_rdata;

  assign imem_ack   = auto_imem ? model_ack : man_ack;
  assign imem_rdata = auto_imem ? model_rdata : man_rdata;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .jmp         (jmp),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc)
  );

  // imem responds on the falling edge once the request has waited ack_delay cycles
  always @(negedge clk) begin
    if (imem_req && wait_cnt >= ack_delay) begin
      model_ack   = 1'b1;
      model_rdata = mem[imem_addr];
    end else begin
      model_ack   = 1'b0;
      model_rdata = 8'h00;
      if (imem_req) wait_cnt = wait_cnt + 1;
      else          wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle into REQ; follows the fetch through to instr_valid and checks the issued word.
  task automatic fetch_one(input logic [4:0] addr, input logic [2:0] op,
                           input logic [4:0] opr, input int cyc);
    int n = 0;
    check("req", 32'(imem_req), 32'd1);
    check("addr", 32'(imem_addr), 32'(addr));
    while (!instr_valid && n < 50) begin
      tick();
      n++;
      if (!instr_valid) begin
        check("req_hold", 32'(imem_req), 32'd1);
        check("addr_hold", 32'(imem_addr), 32'(addr));
      end
    end
    check("latency", 32'(n), 32'(cyc));
    check("valid", 32'(instr_valid), 32'd1);
    check("opcode", 32'(opcode), 32'(op));
    check("operand", 32'(operand), 32'(opr));
    check("pc_at_valid", 32'(pc), 32'(addr));
    check("req_low_in_valid", 32'(imem_req), 32'd0);
  endtask

  task automatic stall(input int cycles, input logic [2:0] op, input logic [4:0] opr,
                       input logic [4:0] exp_pc);
    exec_ready = 1'b0;
    repeat (cycles) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_opcode", 32'(opcode), 32'(op));
      check("stall_operand", 32'(operand), 32'(opr));
      check("stall_pc", 32'(pc), 32'(exp_pc));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'h21;
    mem[1]  = 8'h42;
    mem[2]  = 8'h03;
    mem[3]  = 8'h45;
    mem[4]  = 8'h8A;
    mem[10] = 8'h6E;
    mem[11] = 8'h9F;
    mem[31] = 8'hE7;
    wait_cnt   = 0;
    ack_delay  = 0;
    auto_imem  = 1'b1;
    man_ack    = 1'b0;
    man_rdata  = 8'h00;
    rst_n      = 1'b0;
    run        = 1'b0;
    exec_ready = 1'b1;
    jmp        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_no_run", 32'(imem_req), 32'd0);
    run = 1'b1;

    // zero-wait sequential fetch
    tick(); fetch_one(5'd0, 3'd1, 5'd1, 1);
    tick(); fetch_one(5'd1, 3'd2, 5'd2, 1);
    tick(); fetch_one(5'd2, 3'd0, 5'd3, 1);

    // ack delayed three cycles
    ack_delay = 3;
    tick(); fetch_one(5'd3, 3'd2, 5'd5, 4);
    ack_delay = 0;

    // jump held during a stall must not move pc; taken on accept
    tick(); fetch_one(5'd4, 3'd4, 5'd10, 1);
    jmp = 1'b1;
    stall(5, 3'd4, 5'd10, 5'd4);
    exec_ready = 1'b1;
    tick();
    fetch_one(5'd10, 3'd3, 5'd14, 1);
    jmp = 1'b0;
    stall(5, 3'd3, 5'd14, 5'd10);
    exec_ready = 1'b1;

    // jump to 31, then sequential wrap to 0
    tick(); fetch_one(5'd11, 3'd4, 5'd31, 1);
    jmp = 1'b1;
    tick();
    jmp = 1'b0;
    fetch_one(5'd31, 3'd7, 5'd7, 1);
    tick(); fetch_one(5'd0, 3'd1, 5'd1, 1);

    // run dropped during REQ: finish this instruction then idle, resume at held pc
    tick();
    run = 1'b0;
    fetch_one(5'd1, 3'd2, 5'd2, 1);
    tick();
    check("runoff_req", 32'(imem_req), 32'd0);
    check("runoff_valid", 32'(instr_valid), 32'd0);
    check("runoff_pc", 32'(pc), 32'd2);
    repeat (2) begin
      tick();
      check("idle_req", 32'(imem_req), 32'd0);
    end
    run = 1'b1;
    tick(); fetch_one(5'd2, 3'd0, 5'd3, 1);

    // reset asserted mid-REQ, with a late ack after release
    ack_delay = 100;
    tick();
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_addr", 32'(imem_addr), 32'd3);
    auto_imem = 1'b0;
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_pc", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    man_ack = 1'b1;
    man_rdata = 8'hFF;
    #1 rst_n = 1'b1;
    tick();
    check("late_ack_req", 32'(imem_req), 32'd0);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("late_ack_opcode", 32'(opcode), 32'd0);
    check("late_ack_operand", 32'(operand), 32'd0);
    man_ack = 1'b0;
    ack_delay = 0;
    auto_imem = 1'b1;
    run = 1'b1;
    tick(); fetch_one(5'd0, 3'd1, 5'd1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
